// File: rtl/sram_pkg.sv
// Shared types for the SRAM responder: FSM states, captured operation encoding
// and the data-width derivation used by the top level.
package sram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK
  } resp_state_t;

  typedef enum logic [1:0] {
    OP_READ,
    OP_WRITE,
    OP_ILLEGAL
  } op_t;

  function automatic int dw_of(input int words, input int word_bytes);
    return words * word_bytes * 8;
  endfunction

endpackage

// File: rtl/access_timer.sv
// Loadable 4-bit down-counter that paces the fixed access latency.
module access_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic [3:0] count,
  output logic       zero
);

  logic [3:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == 4'd0);

endmodule

// File: rtl/sram_responder.sv
// Target side of the pixel-controller SRAM interface: small RGB array behind a
// fixed-latency IDLE -> BUSY -> ACK handshake with an error-qualified ack.
module sram_responder
  import sram_pkg::*;
#(
  parameter int W_ADDR_SIZE_BITS  = 16,
  parameter int W_DATA_SIZE_WORDS = 3,
  parameter int W_WORD_SIZE_BYTES = 1,
  parameter int DEPTH             = 64,
  parameter int ACCESS_CYCLES     = 10,
  localparam int DW = dw_of(W_DATA_SIZE_WORDS, W_WORD_SIZE_BYTES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [W_ADDR_SIZE_BITS-1:0] address,
  input  logic                        read_enable,
  input  logic                        write_enable,
  input  logic [DW-1:0]               w_data,
  output logic [DW-1:0]               r_data,
  output logic                        busy,
  output logic                        ack,
  output logic                        err
);

  localparam int IDX_W = $clog2(DEPTH);

  resp_state_t                 state_q, state_d;
  op_t                         op_q, op_d;
  logic [W_ADDR_SIZE_BITS-1:0] addr_q;
  logic [DW-1:0]               wdata_q;
  logic [DW-1:0]               r_data_q;
  logic                        err_q;
  logic [DW-1:0]               mem_q [DEPTH];

  logic       accept;
  logic       do_access;
  logic       in_range;
  logic       timer_en;
  logic [3:0] timer_count;
  logic       timer_zero;

  access_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (4'(ACCESS_CYCLES - 1)),
    .en       (timer_en),
    .count    (timer_count),
    .zero     (timer_zero)
  );

  assign accept    = (state_q == IDLE) && (read_enable || write_enable);
  assign timer_en  = (state_q == BUSY) && (timer_count != 4'd0);
  assign do_access = (state_q == BUSY) && timer_zero;
  // Full address is range-checked; only the low bits index the array.
  assign in_range  = (addr_q < W_ADDR_SIZE_BITS'(DEPTH));

  always_comb begin
    op_d = OP_READ;
    if (read_enable && write_enable) begin
      op_d = OP_ILLEGAL;
    end else if (write_enable) begin
      op_d = OP_WRITE;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (timer_zero) state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_READ;
    end else begin
      state_q <= state_d;
      if (accept) op_q <= op_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= address;
      wdata_q <= w_data;
    end
  end

  // Array, read register and error flag are all cleared by reset, which also
  // drops any write still waiting in BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      r_data_q <= '0;
      err_q    <= 1'b0;
    end else if (do_access) begin
      err_q <= (op_q == OP_ILLEGAL) || !in_range;
      if (in_range && (op_q == OP_READ)) begin
        r_data_q <= mem_q[addr_q[IDX_W-1:0]];
      end
      if (in_range && (op_q == OP_WRITE)) begin
        mem_q[addr_q[IDX_W-1:0]] <= wdata_q;
      end
    end
  end

  assign r_data = r_data_q;
  assign busy   = (state_q == BUSY);
  assign ack    = (state_q == ACK);
  assign err    = (state_q == ACK) && err_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder with hand-computed expectations.
module tb_sram_responder;

  localparam int AC = 10;

  logic        clk;
  logic        rst;
  logic [15:0] address;
  logic        read_enable;
  logic        write_enable;
  logic [23:0] w_data;
  logic [23:0] r_data;
  logic        busy;
  logic        ack;
  logic        err;

  int vectors;
  int miscompares;

  sram_responder #(
    .W_ADDR_SIZE_BITS  (16),
    .W_DATA_SIZE_WORDS (3),
    .W_WORD_SIZE_BYTES (1),
    .DEPTH             (64),
    .ACCESS_CYCLES     (AC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .address      (address),
    .read_enable  (read_enable),
    .write_enable (write_enable),
    .w_data       (w_data),
    .r_data       (r_data),
    .busy         (busy),
    .ack          (ack),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for exactly one edge; returns 1ns after the accepting edge.
  task automatic issue(input logic [15:0] a, input logic re, input logic we, input logic [23:0] wd);
    address      = a;
    read_enable  = re;
    write_enable = we;
    w_data       = wd;
    step();
    read_enable  = 1'b0;
    write_enable = 1'b0;
  endtask

  // Advances until ack is seen (bounded); leaves time inside the ack cycle.
  task automatic wait_ack(output int busy_cnt, output bit got, output int err_leak);
    busy_cnt = 0;
    got      = 1'b0;
    err_leak = 0;
    for (int i = 0; i < 40; i++) begin
      if (ack) begin
        got = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      if (err) err_leak++;
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    address = '0; read_enable = 1'b0; write_enable = 1'b0; w_data = '0;
    step(); step();
    vectors++; if ({busy, ack, err} !== 3'b000) begin miscompares++; $display("FAIL reset_ctrl: got %b want 000", {busy, ack, err}); end
    vectors++; if (r_data !== 24'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 000000", r_data); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_read_latency();
    int n; bit got; int leak;
    issue(16'd5, 1'b1, 1'b0, 24'h0);
    wait_ack(n, got, leak);
    vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL t1_ack_seen: got %b want 1", got); end
    vectors++; if (n !== AC) begin miscompares++; $display("FAIL t1_busy_cycles: got %0d want %0d", n, AC); end
    vectors++; if (leak !== 0) begin miscompares++; $display("FAIL t1_err_without_ack: got %0d want 0", leak); end
    vectors++; if ({r_data, err, busy} !== {24'h0, 1'b0, 1'b0}) begin miscompares++; $display("FAIL t1_ack_cycle: got r=%h e=%b b=%b want 000000 0 0", r_data, err, busy); end
    step();
    vectors++; if (ack !== 1'b0) begin miscompares++; $display("FAIL t1_ack_one_cycle: got %b want 0", ack); end
  endtask

  task automatic test_back_to_back();
    int n; bit got; int leak; int gap;
    issue(16'd3, 1'b0, 1'b1, 24'hFF8040);
    wait_ack(n, got, leak);
    vectors++; if ({got, err, r_data} !== {1'b1, 1'b0, 24'h0}) begin miscompares++; $display("FAIL t2_write_ack: got ack=%b e=%b r=%h want 1 0 000000", got, err, r_data); end
    // Hold a read from the ack cycle onward; it must not be accepted until two edges later.
    address = 16'd3; read_enable = 1'b1;
    gap = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      gap++;
      if (busy) break;
    end
    read_enable = 1'b0;
    vectors++; if (AC + gap !== AC + 2) begin miscompares++; $display("FAIL t2_period: got %0d want %0d", AC + gap, AC + 2); end
    wait_ack(n, got, leak);
    vectors++; if (n !== AC) begin miscompares++; $display("FAIL t2_read_busy: got %0d want %0d", n, AC); end
    vectors++; if ({got, err, r_data} !== {1'b1, 1'b0, 24'hFF8040}) begin miscompares++; $display("FAIL t2_readback: got ack=%b e=%b r=%h want 1 0 ff8040", got, err, r_data); end
    step();
  endtask

  task automatic test_busy_ignores_inputs();
    int n; bit got; int leak; int extra;
    issue(16'd7, 1'b1, 1'b0, 24'h0);
    address = 16'd3; w_data = 24'h123456; write_enable = 1'b1; read_enable = 1'b1;
    step();
    read_enable = 1'b0;
    step();
    read_enable = 1'b1;
    step();
    read_enable = 1'b0; write_enable = 1'b0;
    wait_ack(n, got, leak);
    vectors++; if ({got, err, r_data} !== {1'b1, 1'b0, 24'h0}) begin miscompares++; $display("FAIL t3_captured_read: got ack=%b e=%b r=%h want 1 0 000000", got, err, r_data); end
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (ack) extra++;
    end
    vectors++; if (extra !== 0) begin miscompares++; $display("FAIL t3_single_ack: got %0d extra acks want 0", extra); end
    issue(16'd3, 1'b1, 1'b0, 24'h0);
    wait_ack(n, got, leak);
    vectors++; if ({got, r_data} !== {1'b1, 24'hFF8040}) begin miscompares++; $display("FAIL t3_addr3_kept: got ack=%b r=%h want 1 ff8040", got, r_data); end
    step();
  endtask

  task automatic test_out_of_range();
    int n; bit got; int leak;
    issue(16'd64, 1'b0, 1'b1, 24'h111111);
    wait_ack(n, got, leak);
    vectors++; if ({got, err, r_data} !== {1'b1, 1'b1, 24'hFF8040}) begin miscompares++; $display("FAIL t4_wr_oob: got ack=%b e=%b r=%h want 1 1 ff8040", got, err, r_data); end
    step();
    issue(16'hFFFF, 1'b1, 1'b0, 24'h0);
    wait_ack(n, got, leak);
    vectors++; if ({got, err, r_data} !== {1'b1, 1'b1, 24'hFF8040}) begin miscompares++; $display("FAIL t4_rd_oob: got ack=%b e=%b r=%h want 1 1 ff8040", got, err, r_data); end
    step();
    issue(16'd0, 1'b1, 1'b0, 24'h0);
    wait_ack(n, got, leak);
    vectors++; if ({got, err, r_data} !== {1'b1, 1'b0, 24'h0}) begin miscompares++; $display("FAIL t4_alias0_clean: got ack=%b e=%b r=%h want 1 0 000000", got, err, r_data); end
    step();
    issue(16'd3, 1'b1, 1'b0, 24'h0);
    wait_ack(n, got, leak);
    vectors++; if ({got, err, r_data} !== {1'b1, 1'b0, 24'hFF8040}) begin miscompares++; $display("FAIL t4_addr3_kept: got ack=%b e=%b r=%h want 1 0 ff8040", got, err, r_data); end
    step();
  endtask

  task automatic test_both_enables();
    int n; bit got; int leak;
    issue(16'd2, 1'b0, 1'b1, 24'h0A0B0C);
    wait_ack(n, got, leak);
    step();
    issue(16'd5, 1'b1, 1'b0, 24'h0);
    wait_ack(n, got, leak);
    step();
    issue(16'd2, 1'b1, 1'b1, 24'hDEAD00);
    wait_ack(n, got, leak);
    vectors++; if (n !== AC) begin miscompares++; $display("FAIL t5_busy_cycles: got %0d want %0d", n, AC); end
    vectors++; if ({got, err, r_data} !== {1'b1, 1'b1, 24'h0}) begin miscompares++; $display("FAIL t5_illegal_ack: got ack=%b e=%b r=%h want 1 1 000000", got, err, r_data); end
    step();
    issue(16'd2, 1'b1, 1'b0, 24'h0);
    wait_ack(n, got, leak);
    vectors++; if ({got, err, r_data} !== {1'b1, 1'b0, 24'h0A0B0C}) begin miscompares++; $display("FAIL t5_mem2_kept: got ack=%b e=%b r=%h want 1 0 0a0b0c", got, err, r_data); end
    step();
  endtask

  task automatic test_reset_mid_access();
    int n; bit got; int leak;
    issue(16'd9, 1'b0, 1'b1, 24'hABCDEF);
    repeat (5) step();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL t6_still_busy: got %b want 1", busy); end
    rst = 1'b1;
    #1;
    vectors++; if ({busy, ack, err, r_data} !== {3'b000, 24'h0}) begin miscompares++; $display("FAIL t6_async_reset: got b=%b a=%b e=%b r=%h want 0 0 0 000000", busy, ack, err, r_data); end
    step();
    rst = 1'b0;
    step();
    issue(16'd9, 1'b1, 1'b0, 24'h0);
    wait_ack(n, got, leak);
    vectors++; if ({got, err, r_data} !== {1'b1, 1'b0, 24'h0}) begin miscompares++; $display("FAIL t6_write_aborted: got ack=%b e=%b r=%h want 1 0 000000", got, err, r_data); end
    step();
    issue(16'd2, 1'b1, 1'b0, 24'h0);
    wait_ack(n, got, leak);
    vectors++; if ({got, err, r_data} !== {1'b1, 1'b0, 24'h0}) begin miscompares++; $display("FAIL t6_mem_cleared: got ack=%b e=%b r=%h want 1 0 000000", got, err, r_data); end
    step();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_read_latency();
    test_back_to_back();
    test_busy_ignores_inputs();
    test_out_of_range();
    test_both_enables();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
